// File: rtl/demux_stream_pkg.sv
// -----------------------------------------------------------------------------
// demux_stream_pkg
// Shared definitions for the demux_stream block.
//   state_t        : packet FSM state (IDLE = no packet open, BUSY = packet open)
//   DEFAULT_WIDTH  : default payload width in bits
//   CNT_WIDTH      : width of the optional per-channel packet counters
// Optional feature macro used by the top level: DEMUX_STREAM_CNT_EN
// -----------------------------------------------------------------------------
package demux_stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_WIDTH     = 16;

endpackage : demux_stream_pkg

// File: rtl/demux_stream_reg.sv
// -----------------------------------------------------------------------------
// demux_stream_reg
// Single-entry output register for one demux channel. It can load a new beat,
// hold the current beat under backpressure, or drain it. Loading while the
// current beat drains keeps valid asserted, so the channel sustains one beat
// per cycle.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   load       : write load_data/load_last into the register this cycle
//   load_data  : payload to store
//   load_last  : last flag to store
//   ready      : downstream accepts the held beat
//   valid      : register holds a beat
//   data       : held payload
//   last       : held last flag
// -----------------------------------------------------------------------------
module demux_stream_reg
    import demux_stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             last
);

    // NOTE: the payload is cleared on reset only because the outputs must
    // read zero afterwards; bulk storage would normally be left unreset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            // A load takes priority over a drain: the slot is refilled in the
            // same cycle it empties.
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (ready) begin
            // Drain; data/last keep their old values, only valid drops.
            valid <= 1'b0;
        end
    end

endmodule : demux_stream_reg

// File: rtl/demux_stream.sv
// -----------------------------------------------------------------------------
// demux_stream
// Packet-aware 1-to-2 stream demultiplexer. The destination is sampled from
// in_sel on the first beat of a packet and locked until the beat carrying
// in_last is accepted, so a packet never splits across channels. Each channel
// owns a single-entry register and drains independently of the other.
//
// Ports
//   clk                    : clock, rising edge
//   rst                    : synchronous active-high reset
//   in_data/valid/last     : input beat
//   in_sel                 : destination (0/1), used on a packet's first beat
//   in_ready               : input beat accepted this cycle (when in_valid)
//   outN_data/valid/last   : registered beat for channel N
//   outN_ready             : downstream accepts channel N beat
//   pkt_cnt0/pkt_cnt1      : completed-packet counters per channel, present
//                            only when DEMUX_STREAM_CNT_EN is defined
//
// Configuration macro: DEMUX_STREAM_CNT_EN
// -----------------------------------------------------------------------------
module demux_stream
    import demux_stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    input  logic                 in_sel,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out0_data,
    output logic                 out0_valid,
    output logic                 out0_last,
    input  logic                 out0_ready,
    output logic [WIDTH-1:0]     out1_data,
    output logic                 out1_valid,
    output logic                 out1_last,
`ifdef DEMUX_STREAM_CNT_EN
    output logic [CNT_WIDTH-1:0] pkt_cnt0,
    output logic [CNT_WIDTH-1:0] pkt_cnt1,
`endif
    input  logic                 out1_ready
);

    state_t state_q;
    state_t state_d;
    logic   dest_q;
    logic   dest_d;
    logic   eff_dest;   // destination of the beat currently on the input
    logic   ch0_free;   // channel 0 can take a beat at the next edge
    logic   ch1_free;
    logic   accept;     // input handshake completes this cycle
    logic   load0;
    logic   load1;

    // -------------------------------------------------------------------------
    // Routing and flow control
    // -------------------------------------------------------------------------
    // A channel is free when empty or when its current beat drains this cycle.
    assign ch0_free = !out0_valid || out0_ready;
    assign ch1_free = !out1_valid || out1_ready;

    // Inside an open packet the locked destination wins over in_sel.
    assign eff_dest = (state_q == BUSY) ? dest_q : in_sel;

    // in_ready looks only at the destination channel, never at in_valid, so
    // the other channel stalling cannot block this packet.
    assign in_ready = eff_dest ? ch1_free : ch0_free;
    assign accept   = in_valid && in_ready;

    assign load0 = accept && !eff_dest;
    assign load1 = accept &&  eff_dest;

    // -------------------------------------------------------------------------
    // Packet FSM
    // -------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dest_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
        end
    end

    // NOTE: defaults are assigned first so every path drives every output and
    // no latch is inferred.
    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    dest_d = in_sel;
                    // A single-beat packet opens and closes in one cycle.
                    state_d = in_last ? IDLE : BUSY;
                end
            end
            BUSY: begin
                if (accept && in_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Channel registers
    // -------------------------------------------------------------------------
    demux_stream_reg #(
        .WIDTH(WIDTH)
    ) u_ch0 (
        .clk       (clk),
        .rst       (rst),
        .load      (load0),
        .load_data (in_data),
        .load_last (in_last),
        .ready     (out0_ready),
        .valid     (out0_valid),
        .data      (out0_data),
        .last      (out0_last)
    );

    demux_stream_reg #(
        .WIDTH(WIDTH)
    ) u_ch1 (
        .clk       (clk),
        .rst       (rst),
        .load      (load1),
        .load_data (in_data),
        .load_last (in_last),
        .ready     (out1_ready),
        .valid     (out1_valid),
        .data      (out1_data),
        .last      (out1_last)
    );

`ifdef DEMUX_STREAM_CNT_EN
    // -------------------------------------------------------------------------
    // Completed-packet counters; they wrap naturally at 2**CNT_WIDTH.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else if (accept && in_last) begin
            if (eff_dest) begin
                pkt_cnt1 <= pkt_cnt1 + 1'b1;
            end else begin
                pkt_cnt0 <= pkt_cnt0 + 1'b1;
            end
        end
    end
`endif

endmodule : demux_stream

// File: tb/tb_demux_stream.sv
// -----------------------------------------------------------------------------
// tb_demux_stream
// Self-checking bench for demux_stream. The stimulus process keeps a packet-
// level model (is a packet open, where is it going, how many beats sit in each
// one-deep channel) and pushes every accepted beat into the queue of its
// channel. An independent monitor compares each presented channel beat with
// the head of that channel's queue and pops it on a downstream handshake.
// Define DEMUX_STREAM_CNT_EN to also exercise the packet counters.
// -----------------------------------------------------------------------------
module tb_demux_stream;
    import demux_stream_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_sel = 1'b0;
    logic         in_ready;
    logic [W-1:0] out0_data;
    logic         out0_valid;
    logic         out0_last;
    logic         out0_ready = 1'b0;
    logic [W-1:0] out1_data;
    logic         out1_valid;
    logic         out1_last;
    logic         out1_ready = 1'b0;
`ifdef DEMUX_STREAM_CNT_EN
    logic [CNT_WIDTH-1:0] pkt_cnt0;
    logic [CNT_WIDTH-1:0] pkt_cnt1;
`endif

    demux_stream #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_sel     (in_sel),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_last  (out0_last),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_last  (out1_last),
`ifdef DEMUX_STREAM_CNT_EN
        .pkt_cnt0   (pkt_cnt0),
        .pkt_cnt1   (pkt_cnt1),
`endif
        .out1_ready (out1_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    // Reference model state
    beat_t       q0[$];
    beat_t       q1[$];
    bit          occ0;
    bit          occ1;
    bit          pkt_open;
    bit          pkt_dest;
    logic [15:0] cnt_m0;
    logic [15:0] cnt_m1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        q0.delete();
        q1.delete();
        occ0     = 1'b0;
        occ1     = 1'b0;
        pkt_open = 1'b0;
        pkt_dest = 1'b0;
        cnt_m0   = '0;
        cnt_m1   = '0;
    endtask

    // One clock cycle of stimulus: drive inputs shortly after the edge, check
    // the combinational ready and the registered valids, then advance the model.
    task automatic step(input bit v, input logic [W-1:0] d, input bit l,
                        input bit s, input bit r0, input bit r1);
        bit    dd;
        bit    rdy;
        beat_t b;
        @(posedge clk);
        #2;
        rst        = 1'b0;
        in_valid   = v;
        in_data    = d;
        in_last    = l;
        in_sel     = s;
        out0_ready = r0;
        out1_ready = r1;
        #1;
        check("out0_valid", out0_valid, occ0);
        check("out1_valid", out1_valid, occ1);
`ifdef DEMUX_STREAM_CNT_EN
        check("pkt_cnt0", pkt_cnt0, cnt_m0);
        check("pkt_cnt1", pkt_cnt1, cnt_m1);
`endif
        dd  = pkt_open ? pkt_dest : s;
        rdy = dd ? (!occ1 || r1) : (!occ0 || r0);
        check("in_ready", in_ready, rdy);
        if (occ0 && r0) occ0 = 1'b0;
        if (occ1 && r1) occ1 = 1'b0;
        if (v && rdy) begin
            b.data = d;
            b.last = l;
            if (dd) begin
                q1.push_back(b);
                occ1 = 1'b1;
                if (l) cnt_m1 = cnt_m1 + 16'd1;
            end else begin
                q0.push_back(b);
                occ0 = 1'b1;
                if (l) cnt_m0 = cnt_m0 + 16'd1;
            end
            if (!pkt_open) begin
                pkt_dest = s;
                pkt_open = !l;
            end else if (l) begin
                pkt_open = 1'b0;
            end
        end
    endtask

    // One reset cycle with a live beat on the input, which must be discarded.
    task automatic reset_cycle();
        @(posedge clk);
        #2;
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_data    = W'($urandom);
        in_last    = 1'($urandom);
        in_sel     = 1'($urandom);
        out0_ready = 1'($urandom);
        out1_ready = 1'($urandom);
        clear_model();
    endtask

    // Monitor: every presented beat must match the head of its channel queue;
    // the head is popped only when the downstream handshake completes.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out0_valid) begin
                    if (q0.size() == 0) begin
                        check("ch0_unexpected_beat", out0_valid, 1'b0);
                    end else begin
                        check("ch0_data", out0_data, q0[0].data);
                        check("ch0_last", out0_last, q0[0].last);
                        if (out0_ready) void'(q0.pop_front());
                    end
                end
                if (out1_valid) begin
                    if (q1.size() == 0) begin
                        check("ch1_unexpected_beat", out1_valid, 1'b0);
                    end else begin
                        check("ch1_data", out1_data, q1[0].data);
                        check("ch1_last", out1_last, q1[0].last);
                        if (out1_ready) void'(q1.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        clear_model();
        // Reset state
        repeat (2) @(posedge clk);
        #3;
        check("rst_out0_valid", out0_valid, 1'b0);
        check("rst_out1_valid", out1_valid, 1'b0);
        check("rst_out0_data", out0_data, 8'h00);
        check("rst_out1_data", out1_data, 8'h00);
        check("rst_out0_last", out0_last, 1'b0);
        check("rst_out1_last", out1_last, 1'b0);

        // Single beat to channel 1
        step(1, 8'hA5, 1, 1, 1, 1);
        step(0, 8'h00, 0, 0, 1, 1);
        check("single_out1_valid", out1_valid, 1'b1);
        check("single_out1_data", out1_data, 8'hA5);
        check("single_out0_valid", out0_valid, 1'b0);
        // FSM is idle again: the next beat follows in_sel=0
        step(1, 8'h5A, 1, 0, 1, 1);
        step(0, 8'h00, 0, 0, 1, 1);
        check("single_next_out0_data", out0_data, 8'h5A);

        // Destination lock across a 3-beat packet
        step(1, 8'h11, 0, 0, 1, 1);
        step(1, 8'h22, 0, 1, 1, 1);
        step(1, 8'h33, 1, 1, 1, 1);
        check("lock_out1_valid", out1_valid, 1'b0);
        step(1, 8'h44, 1, 1, 1, 1);
        step(0, 8'h00, 0, 0, 1, 1);
        check("lock_release_out1_data", out1_data, 8'h44);

        // Backpressure on channel 0
        step(1, 8'h01, 1, 0, 0, 1);
        step(1, 8'h02, 1, 0, 0, 1);
        check("bp_in_ready_low", in_ready, 1'b0);
        step(1, 8'h02, 1, 0, 0, 1);
        check("bp_data_held", out0_data, 8'h01);
        step(1, 8'h02, 1, 0, 1, 1);
        step(1, 8'h03, 1, 0, 1, 1);
        step(1, 8'h04, 1, 0, 1, 1);
        step(0, 8'h00, 0, 0, 1, 1);
        check("bp_final_data", out0_data, 8'h04);

        // Channel 1 stalled while channel 0 streams a packet
        step(1, 8'h77, 1, 1, 1, 0);
        step(1, 8'h81, 0, 0, 1, 0);
        check("indep_in_ready", in_ready, 1'b1);
        step(1, 8'h82, 0, 0, 1, 0);
        step(1, 8'h83, 1, 0, 1, 0);
        check("indep_ch1_held", out1_data, 8'h77);
        step(0, 8'h00, 0, 0, 1, 1);

        // Reset in the middle of a 4-beat packet
        step(1, 8'hC1, 0, 0, 1, 1);
        step(1, 8'hC2, 0, 0, 1, 1);
        reset_cycle();
        step(1, 8'h99, 1, 1, 1, 1);
        check("rstmid_out0_valid", out0_valid, 1'b0);
        step(0, 8'h00, 0, 0, 1, 1);
        check("rstmid_out1_data", out1_data, 8'h99);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset_cycle();
            end else begin
                step(1'($urandom_range(0, 3) != 0), W'($urandom),
                     1'($urandom_range(0, 3) == 0), 1'($urandom),
                     1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
            end
        end

        // Drain and confirm nothing was lost
        repeat (4) step(0, 8'h00, 0, 0, 1, 1);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

`ifdef DEMUX_STREAM_CNT_EN
        // Counter wrap: 65537 single-beat packets to channel 0
        reset_cycle();
        for (int i = 0; i < 65537; i++) begin
            step(1, W'(i), 1, 0, 1, 1);
        end
        step(0, 8'h00, 0, 0, 1, 1);
        check("wrap_pkt_cnt0", pkt_cnt0, 16'd1);
        check("wrap_pkt_cnt1", pkt_cnt1, 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_demux_stream

// File: doc/demux_stream.md
DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 Parameter WIDTH, default 8, sets the data width in bits of the input and both output channels.
REQ-002 clk  input  1  Single clock; all state updates on the rising edge.
REQ-003 rst  input  1  Reset, synchronous and active-high.
REQ-004 in_data  input  WIDTH  Input beat payload.
REQ-005 in_valid  input  1  Input beat is present.
REQ-006 in_last  input  1  Beat is the final beat of its packet.
REQ-007 in_sel  input  1  Destination: 0 selects channel 0, 1 selects channel 1; sampled on a packet's first beat only.
REQ-008 in_ready  output  1  Block accepts the beat this cycle.
REQ-009 out0_data / out1_data  output  WIDTH  Registered payload per channel.
REQ-010 out0_valid / out1_valid  output  1  Channel register holds a beat.
REQ-011 out0_last / out1_last  output  1  Registered last flag per channel.
REQ-012 out0_ready / out1_ready  input  1  Downstream accepts the channel beat.

Function
REQ-013 A beat transfers on the input when in_valid and in_ready are both 1; it transfers on channel k when outk_valid and outk_ready are both 1.
REQ-014 FSM states: IDLE (no packet open) and BUSY (packet open, destination locked).
REQ-015 In IDLE, an accepted beat latches in_sel as dest; the FSM goes to BUSY if in_last=0 and stays IDLE if in_last=1.
REQ-016 In BUSY, in_sel is ignored and beats route to the latched dest; the FSM returns to IDLE when a beat with in_last=1 is accepted.
REQ-017 in_ready = (!outd_valid || outd_ready), where d is the effective destination: in_sel in IDLE, dest in BUSY; in_ready is combinational from these terms and independent of in_valid.
REQ-018 An accepted beat appears on outd_* on the next cycle (latency 1), with data and last unchanged.
REQ-019 If a channel is drained and refilled in the same cycle, its register loads the new beat and outk_valid stays 1 (full throughput, one beat per cycle).
REQ-020 Each channel register holds data and last stable while outk_valid=1 and outk_ready=0.
REQ-021 The non-destination channel is never written; it drains independently, including during the other channel's packet.
REQ-022 A packet never interleaves beats to the other channel.

Reset
REQ-023 While rst=1 at a clock edge: FSM goes to IDLE, dest=0, out0_valid=out1_valid=0, out0_last=out1_last=0, out0_data=out1_data=0.
REQ-024 Reset mid-packet discards the open packet and any buffered beats; the first accepted beat after reset starts a new packet.
REQ-025 in_ready may be 1 during reset; beats presented while rst=1 are discarded.

Configuration
REQ-026 Macro DEMUX_STREAM_CNT_EN, when defined, adds outputs pkt_cnt0 and pkt_cnt1 (16 bits each), incremented on each accepted in_last=1 beat routed to that channel, wrapping 16'hFFFF to 0, and cleared by reset.
REQ-027 Without DEMUX_STREAM_CNT_EN, these ports and their logic do not exist and all other behaviour is identical.

Structure
REQ-028 Package demux_stream_pkg holds the FSM state enum (IDLE, BUSY), default WIDTH constant and counter width constant (16).
REQ-029 Sub-module demux_stream_reg implements one single-entry channel register (load, hold, drain); two instances, one per channel.

Verification
REQ-030 Single beat: in_sel=1, in_last=1, data=8'hA5, out1_ready=1 -> out1_valid=1 with data A5 one cycle later; out0_valid stays 0; FSM stays IDLE.
REQ-031 Lock: 3-beat packet 11,22,33 with first-beat in_sel=0, then in_sel toggled to 1 on beats 2-3 -> all three beats appear on channel 0, then FSM returns to IDLE.
REQ-032 Backpressure: out0_ready=0 with channel 0 full -> in_ready=0 for dest 0 and data held; raise out0_ready -> one beat per cycle with no loss or duplication.
REQ-033 Independence: channel 1 stalled holding a beat, new packet to channel 0 -> in_ready=1 and channel 0 streams while channel 1 holds.
REQ-034 Reset mid-packet: rst pulsed after beat 2 of 4 -> all valids 0 next cycle; next beat with in_sel=1 routes to channel 1.
REQ-035 With DEMUX_STREAM_CNT_EN: 65537 single-beat packets to channel 0 -> pkt_cnt0=1, pkt_cnt1=0.
